updown_counter: RTL and testbench

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/updown_counter.sv | 54 +++++
 tb/tb_updown_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// updown_counter: up/down counter with wrap or saturate boundary handling and a one-cycle ovf pulse.
// Define UPDOWN_COUNTER_PRESCALE_EN to gate steps with a PRESCALE_DIV tick prescaler.
module updown_counter #(
   parameter int WIDTH        = 8,
   parameter int WRAP         = 1,
   parameter int PRESCALE_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);
   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("updown_counter: WIDTH out of range");
   end
   if (PRESCALE_DIV < 2 || PRESCALE_DIV > 256) begin : g_bad_div
      $error("updown_counter: PRESCALE_DIV out of range");
   end
   logic tick;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
   localparam int PW = $clog2(PRESCALE_DIV);
   logic [PW-1:0] pre;
   assign tick = (pre == PW'(PRESCALE_DIV - 1));
   // prescaler only runs on enabled, non-load edges so en=0 freezes the period
   always_ff @(posedge clk or posedge reset)
      if (reset) pre <= '0;
      else if (load) pre <= '0;
      else if (en) pre <= tick ? '0 : pre + PW'(1);
`else
   assign tick = 1'b1;
`endif
   logic [WIDTH-1:0] next_val;
   assign tc       = up ? (count == '1) : (count == '0);
   assign next_val = up ? count + WIDTH'(1) : count - WIDTH'(1);
   // tc doubles as "this step crosses the boundary"
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (load) begin
         count <= data;
         ovf   <= 1'b0;
      end else if (en && tick) begin
         count <= (tc && WRAP == 0) ? count : next_val;
         ovf   <= tc;
      end else begin
         ovf   <= 1'b0;
      end
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: randomized bench comparing wrap and saturate instances against an integer model.
module tb_updown_counter;
   localparam int W = 8, MAXV = 255, PDIV = 4;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
   localparam int PER = PDIV;
`else
   localparam int PER = 1;
`endif
   logic clk = 0, reset = 0, load = 0, en = 0, up = 1;
   logic [W-1:0] data = '0;
   logic [W-1:0] cnt_w, cnt_s;
   logic tc_w, tc_s, ovf_w, ovf_s;
   int mw = 0, ms = 0, mpre = 0;
   bit mow = 0, mos = 0, live = 0;
   int n_pass = 0, n_tot = 0;

   always #5 clk = ~clk;

   updown_counter #(.WIDTH(W), .WRAP(1), .PRESCALE_DIV(PDIV)) dut_w (
      .clk(clk), .reset(reset), .load(load), .data(data), .en(en), .up(up),
      .count(cnt_w), .tc(tc_w), .ovf(ovf_w));
   updown_counter #(.WIDTH(W), .WRAP(0), .PRESCALE_DIV(PDIV)) dut_s (
      .clk(clk), .reset(reset), .load(load), .data(data), .en(en), .up(up),
      .count(cnt_s), .tc(tc_s), .ovf(ovf_s));

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   function automatic bit out_of_range(int c, bit u);
      int n = u ? c + 1 : c - 1;
      return n > MAXV || n < 0;
   endfunction

   function automatic int nxt(int c, bit u, bit wr);
      int n = u ? c + 1 : c - 1;
      if (!out_of_range(c, u)) return n;
      return wr ? (n + MAXV + 1) % (MAXV + 1) : c;
   endfunction

   function automatic bit mtick(int p);
`ifdef UPDOWN_COUNTER_PRESCALE_EN
      return p == PDIV - 1;
`else
      return 1'b1;
`endif
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mw <= 0; ms <= 0; mow <= 0; mos <= 0; mpre <= 0;
      end else if (load) begin
         mw <= int'(data); ms <= int'(data); mow <= 0; mos <= 0; mpre <= 0;
      end else if (en && mtick(mpre)) begin
         mw <= nxt(mw, up, 1'b1); ms <= nxt(ms, up, 1'b0);
         mow <= out_of_range(mw, up); mos <= out_of_range(ms, up);
         mpre <= 0;
      end else begin
         mow <= 0; mos <= 0;
         if (en) mpre <= (mpre + 1) % PDIV;
      end
   end

   always @(negedge clk) if (live) begin
      chk("model_cnt_w", cnt_w, mw);
      chk("model_ovf_w", ovf_w, mow);
      chk("model_tc_w", tc_w, up ? mw == MAXV : mw == 0);
      chk("model_cnt_s", cnt_s, ms);
      chk("model_ovf_s", ovf_s, mos);
      chk("model_tc_s", tc_s, up ? ms == MAXV : ms == 0);
   end

   task automatic edge_();
      @(posedge clk); #1;
   endtask

   task automatic do_load(logic [W-1:0] v);
      load = 1; data = v; edge_(); load = 0;
   endtask

   initial begin
      int ew[3], es[3], ow[3], os[3];
      #1 reset = 1;
      edge_(); edge_();
      chk("reset_cnt", cnt_w, 0);
      chk("reset_ovf", ovf_w, 0);
      reset = 0; live = 1;
      // asynchronous reset mid-count
      do_load(8'h37);
      chk("load_37", cnt_w, 8'h37);
      #2 reset = 1;
      #1 chk("async_rst_cnt_w", cnt_w, 0);
      chk("async_rst_cnt_s", cnt_s, 0);
      chk("async_rst_ovf", ovf_w, 0);
      load = 1; data = 8'h55; en = 1;
      edge_();
      chk("rst_ignores_load", cnt_w, 0);
      reset = 0; load = 0; en = 0;
      // load wins over an enabled step
      load = 1; data = 8'hA5; en = 1; up = 1;
      edge_();
      chk("load_prio_cnt", cnt_w, 8'hA5);
      chk("load_prio_ovf", ovf_w, 0);
      load = 0; en = 0;
      // up across all-ones
      do_load(8'hFE);
      en = 1; up = 1;
      ew = '{255, 0, 1}; ow = '{0, 1, 0}; es = '{255, 255, 255}; os = '{0, 1, 1};
      for (int k = 0; k < 3; k++) begin
         repeat (PER) edge_();
         chk("upwrap_cnt", cnt_w, ew[k]);
         chk("upwrap_ovf", ovf_w, ow[k]);
         chk("upsat_cnt", cnt_s, es[k]);
         chk("upsat_ovf", ovf_s, os[k]);
         if (k == 0) chk("upwrap_tc", tc_w, 1);
      end
      en = 0;
      // down across zero
      do_load(8'h01);
      en = 1; up = 0;
      es = '{0, 0, 0}; os = '{0, 1, 1}; ew = '{0, 255, 254}; ow = '{0, 1, 0};
      for (int k = 0; k < 3; k++) begin
         repeat (PER) edge_();
         chk("dnsat_cnt", cnt_s, es[k]);
         chk("dnsat_ovf", ovf_s, os[k]);
         chk("dnwrap_cnt", cnt_w, ew[k]);
         chk("dnwrap_ovf", ovf_w, ow[k]);
      end
      en = 0; up = 1;
      // eight enabled edges from zero
      do_load(8'h00);
      en = 1;
      repeat (3) edge_();
      chk("pre_after3", cnt_w, PER == 4 ? 0 : 3);
      repeat (5) edge_();
      chk("pre_after8", cnt_w, PER == 4 ? 2 : 8);
      // en dropped mid-period delays the step
      en = 0;
      do_load(8'h00);
      en = 1; repeat (2) edge_();
      en = 0; repeat (2) edge_();
      en = 1; edge_();
      chk("pre_hold5", cnt_w, PER == 4 ? 0 : 3);
      edge_();
      chk("pre_hold6", cnt_w, PER == 4 ? 1 : 4);
      // randomized traffic, boundary-biased loads
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) == 0) begin
            reset = 1; edge_(); reset = 0;
         end else begin
            load = ($urandom_range(7) == 0);
            case ($urandom_range(4))
               0: data = 8'h00;
               1: data = 8'h01;
               2: data = 8'hFE;
               3: data = 8'hFF;
               default: data = W'($urandom);
            endcase
            en = ($urandom_range(3) != 0);
            up = 1'($urandom_range(1));
            edge_();
         end
      end
      load = 0; en = 0;
      edge_();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
